// File: rtl/mips_dbg_pkg.sv
// Shared types and default constants for the mips debug/stimulus controller.
package mips_dbg_pkg;

  typedef enum logic [1:0] {HOLD, IDLE, STEP, SCAN} dbg_state_e;

  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RST_CYCLES = 5;
  localparam int DEF_SCAN_DEPTH = 32;
  localparam int DEF_IRQ_CH     = 2;
  localparam int DEF_CNT_W      = 32;

  // One address-drive cycle per entry plus one trailing cycle for the last write.
  localparam int DEF_SCAN_LEN   = DEF_SCAN_DEPTH + 1;

  function automatic int scan_len(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/mips_dbg_snap_ram.sv
// Snapshot storage: one synchronous write port, one asynchronous read port, no reset.
module mips_dbg_snap_ram #(
  parameter int DEPTH = 32,
  parameter int IW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A same-cycle read of the written address sees the old word.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mips_dbg_ctrl.sv
// Debug/stimulus controller for the mips core: reset hold, step/run, post-step snapshot, IRQ injection.
// Optional previous-bank comparison enabled with `define MIPS_DBG_SCAN_CMP_EN.
module mips_dbg_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int SCAN_DEPTH = DEF_SCAN_DEPTH,
  parameter int IRQ_CH     = DEF_IRQ_CH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    step_req,
  output logic                    cpu_rst,
  output logic                    debug_en,
  output logic                    debug_step,
  output logic [ADDR_W-1:0]       debug_addr,
  input  logic [DATA_W-1:0]       debug_data,
  input  logic [ADDR_W-1:0]       snap_raddr,
  output logic [DATA_W-1:0]       snap_rdata,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic [CNT_W-1:0]        step_cnt,
  input  logic [IRQ_CH-1:0]       irq_arm,
  input  logic [IRQ_CH*CNT_W-1:0] irq_at,
  output logic [IRQ_CH-1:0]       interrupter,
`ifdef MIPS_DBG_SCAN_CMP_EN
  output logic                    snap_diff,
  output logic [ADDR_W-1:0]       diff_addr,
`endif
  output dbg_state_e              state_o
);

  localparam int SCAN_LEN = scan_len(SCAN_DEPTH);
  localparam int SC_W     = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam int HC_W     = $clog2(RST_CYCLES + 1);
  localparam int IW       = (SCAN_DEPTH > 1) ? $clog2(SCAN_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = SCAN_DEPTH[ADDR_W:0];

  dbg_state_e        state_q;
  logic [HC_W-1:0]   hold_q;
  logic [SC_W-1:0]   scan_q;
  logic              cpu_rst_q, debug_en_q, debug_step_q, scan_done_q;
  logic [ADDR_W-1:0] debug_addr_q;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [IRQ_CH-1:0] irq_q, irq_d;

  logic              step_go, cnt_inc, wr_en, rd_ok;
  logic [IW-1:0]     wr_idx;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    step_go    = (state_q == IDLE) && !run && step_req;
    cnt_inc    = (state_q == IDLE) && (run || step_req);
    step_cnt_d = cnt_inc ? step_cnt_q + CNT_W'(1) : step_cnt_q;
    irq_d      = '0;
    for (int i = 0; i < IRQ_CH; i++) begin
      irq_d[i] = cnt_inc && irq_arm[i] && (step_cnt_d == irq_at[i*CNT_W +: CNT_W]);
    end
    // scan_q counts SCAN cycles; the word for address n lands in cycle n+1.
    wr_en  = (state_q == SCAN) && (scan_q != '0) && !rst;
    wr_idx = IW'(scan_q - SC_W'(1));
    rd_ok  = {1'b0, snap_raddr} < DEPTH_V;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      hold_q       <= HC_W'(RST_CYCLES);
      scan_q       <= '0;
      cpu_rst_q    <= 1'b1;
      debug_en_q   <= 1'b1;
      debug_step_q <= 1'b0;
      debug_addr_q <= '0;
      scan_done_q  <= 1'b0;
      step_cnt_q   <= '0;
      irq_q        <= '0;
    end else begin
      step_cnt_q   <= step_cnt_d;
      irq_q        <= irq_d;
      debug_step_q <= 1'b0;
      scan_done_q  <= 1'b0;
      case (state_q)
        HOLD: begin
          if (hold_q == HC_W'(1)) begin
            state_q   <= IDLE;
            cpu_rst_q <= 1'b0;
          end else begin
            hold_q <= hold_q - HC_W'(1);
          end
        end
        IDLE: begin
          debug_en_q <= ~run;
          if (step_go) begin
            state_q      <= STEP;
            debug_step_q <= 1'b1;
            debug_en_q   <= 1'b1;
          end
        end
        STEP: begin
          state_q      <= SCAN;
          scan_q       <= '0;
          debug_addr_q <= '0;
        end
        SCAN: begin
          scan_q <= scan_q + SC_W'(1);
          if (scan_q == SC_W'(SCAN_DEPTH)) begin
            state_q <= IDLE;
          end else if (scan_q == SC_W'(SCAN_DEPTH - 1)) begin
            scan_done_q  <= 1'b1;
            debug_addr_q <= '0;
          end else begin
            debug_addr_q <= debug_addr_q + ADDR_W'(1);
          end
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  mips_dbg_snap_ram #(.DEPTH(SCAN_DEPTH), .IW(IW), .DW(DATA_W)) u_snap (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_idx),
    .wdata (debug_data),
    .raddr (snap_raddr[IW-1:0]),
    .rdata (ram_rdata)
  );

`ifdef MIPS_DBG_SCAN_CMP_EN
  logic [DATA_W-1:0] prev_word;
  logic              word_neq, diff_q;
  logic [ADDR_W-1:0] daddr_q;

  mips_dbg_snap_ram #(.DEPTH(SCAN_DEPTH), .IW(IW), .DW(DATA_W)) u_prev (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_idx),
    .wdata (debug_data),
    .raddr (wr_idx),
    .rdata (prev_word)
  );

  assign word_neq = wr_en && (prev_word != debug_data);

  // Ascending sweep, so the first difference seen is the lowest address.
  always_ff @(posedge clk) begin
    if (rst || step_go) begin
      diff_q  <= 1'b0;
      daddr_q <= '0;
    end else if (word_neq && !diff_q) begin
      diff_q  <= 1'b1;
      daddr_q <= ADDR_W'(wr_idx);
    end
  end

  assign snap_diff = diff_q | word_neq;
  assign diff_addr = diff_q ? daddr_q : (word_neq ? ADDR_W'(wr_idx) : '0);
`endif

  assign cpu_rst     = cpu_rst_q;
  assign debug_en    = debug_en_q;
  assign debug_step  = debug_step_q;
  assign debug_addr  = debug_addr_q;
  assign scan_done   = scan_done_q;
  assign scan_busy   = (state_q == STEP) || (state_q == SCAN);
  assign step_cnt    = step_cnt_q;
  assign interrupter = irq_q;
  assign snap_rdata  = rd_ok ? ram_rdata : '0;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_dbg_ctrl.sv
// Directed-sequence bench for mips_dbg_ctrl with randomized core register contents and a behavioural model.
module tb_mips_dbg_ctrl;
  import mips_dbg_pkg::*;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 32;
  localparam int RST_CYCLES = 5;
  localparam int SCAN_DEPTH = 32;
  localparam int IRQ_CH     = 2;
  localparam int CNT_W      = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst = 1'b1, run = 1'b0, step_req = 1'b0;
  logic                    cpu_rst, debug_en, debug_step, scan_busy, scan_done;
  logic [ADDR_W-1:0]       debug_addr, snap_raddr = '0;
  logic [DATA_W-1:0]       debug_data = '0, snap_rdata;
  logic [CNT_W-1:0]        step_cnt;
  logic [IRQ_CH-1:0]       irq_arm = '0, interrupter;
  logic [IRQ_CH*CNT_W-1:0] irq_at = '0;
  dbg_state_e              st;
`ifdef MIPS_DBG_SCAN_CMP_EN
  logic                    snap_diff;
  logic [ADDR_W-1:0]       diff_addr;
`endif

  mips_dbg_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES),
    .SCAN_DEPTH(SCAN_DEPTH), .IRQ_CH(IRQ_CH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step_req(step_req),
    .cpu_rst(cpu_rst), .debug_en(debug_en), .debug_step(debug_step),
    .debug_addr(debug_addr), .debug_data(debug_data),
    .snap_raddr(snap_raddr), .snap_rdata(snap_rdata),
    .scan_busy(scan_busy), .scan_done(scan_done), .step_cnt(step_cnt),
    .irq_arm(irq_arm), .irq_at(irq_at), .interrupter(interrupter),
`ifdef MIPS_DBG_SCAN_CMP_EN
    .snap_diff(snap_diff), .diff_addr(diff_addr),
`endif
    .state_o(st)
  );

  // core model: register file read back one cycle after the address
  logic [DATA_W-1:0] core_regs [0:(1<<ADDR_W)-1];
  always @(posedge clk) debug_data <= core_regs[debug_addr];

  // scoreboard state
  int                vectors = 0;
  int                miscompares = 0;
  logic [CNT_W-1:0]  exp_cnt = '0;
  logic [DATA_W-1:0] snap_m [0:SCAN_DEPTH-1];
  bit                snap_known = 1'b0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_regs();
    for (int k = 0; k < (1 << ADDR_W); k++) core_regs[k] = $urandom;
  endtask

  task automatic check_snapshot(input string tag);
    for (int k = 0; k < SCAN_DEPTH; k++) exp_q.push_back(snap_m[k]);
    for (int k = 0; k < SCAN_DEPTH; k++) begin
      snap_raddr = ADDR_W'(k);
      #1;
      chk($sformatf("%s[%0d]", tag, k), snap_rdata, exp_q.pop_front());
    end
  endtask

  // Request one step, follow it to completion and check everything it should produce.
  task automatic do_step(input string tag, input bit hold_req);
    int                n, lat, steps_seen, bad, exp_diff;
    logic [ADDR_W-1:0] addr_q [$];
    logic [IRQ_CH-1:0] irq_step, irq_other, irq_exp;
    logic [CNT_W-1:0]  new_cnt;
    bit                got_diff;
    logic [ADDR_W-1:0] got_daddr;
    n = 0; lat = -1; steps_seen = 0; bad = 0;
    irq_step = '0; irq_other = '0; got_diff = 1'b0; got_daddr = '0;
    step_req = 1'b1;
    while (lat < 0 && n < 200) begin
      tick();
      n++;
      if (!hold_req) step_req = 1'b0;
      if (debug_step) begin
        steps_seen++;
        irq_step = interrupter;
      end else begin
        irq_other |= interrupter;
      end
      if (scan_done) begin
        lat = n;
        step_req = 1'b0;
`ifdef MIPS_DBG_SCAN_CMP_EN
        got_diff = snap_diff;
        got_daddr = diff_addr;
`endif
      end else if (scan_busy && !debug_step) begin
        addr_q.push_back(debug_addr);
      end
    end
    step_req = 1'b0;
    tick();
    // model
    new_cnt = exp_cnt + CNT_W'(1);
    exp_cnt = new_cnt;
    for (int i = 0; i < IRQ_CH; i++)
      irq_exp[i] = irq_arm[i] && (irq_at[i*CNT_W +: CNT_W] == new_cnt);
    exp_diff = -1;
    for (int k = SCAN_DEPTH - 1; k >= 0; k--)
      if (core_regs[k] !== snap_m[k]) exp_diff = k;
    if (addr_q.size() != SCAN_DEPTH) bad++;
    foreach (addr_q[k]) if (addr_q[k] != ADDR_W'(k)) bad++;
    chk({tag, "_latency"}, lat, SCAN_DEPTH + 2);
    chk({tag, "_step_pulses"}, steps_seen, 1);
    chk({tag, "_step_cnt"}, step_cnt, exp_cnt);
    chk({tag, "_irq_on_step"}, irq_step, irq_exp);
    chk({tag, "_irq_elsewhere"}, irq_other, '0);
    chk({tag, "_addr_sweep_errs"}, bad, 0);
    chk({tag, "_idle_after"}, st, IDLE);
    chk({tag, "_busy_after"}, scan_busy, 1'b0);
    chk({tag, "_addr_after"}, debug_addr, '0);
`ifdef MIPS_DBG_SCAN_CMP_EN
    if (snap_known) begin
      chk({tag, "_snap_diff"}, got_diff, exp_diff >= 0);
      chk({tag, "_diff_addr"}, got_daddr, (exp_diff >= 0) ? ADDR_W'(exp_diff) : '0);
    end
`else
    if (got_diff || got_daddr != '0) bad++;
`endif
    for (int k = 0; k < SCAN_DEPTH; k++) snap_m[k] = core_regs[k];
    snap_known = 1'b1;
    check_snapshot({tag, "_snap"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_done;
    randomize_regs();

    // reset values
    repeat (3) tick();
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_debug_en", debug_en, 1'b1);
    chk("rst_debug_step", debug_step, 1'b0);
    chk("rst_debug_addr", debug_addr, '0);
    chk("rst_scan_busy", scan_busy, 1'b0);
    chk("rst_scan_done", scan_done, 1'b0);
    chk("rst_step_cnt", step_cnt, '0);
    chk("rst_interrupter", interrupter, '0);
    chk("rst_state", st, HOLD);

    // reset hold length; step_req must be ignored while holding
    rst = 1'b0;
    step_req = 1'b1;
    n = 0;
    while (cpu_rst === 1'b1 && n < 50) begin tick(); n++; end
    step_req = 1'b0;
    chk("hold_cycles", n, RST_CYCLES);
    chk("hold_idle", st, IDLE);
    chk("hold_debug_en", debug_en, 1'b1);
    chk("hold_step_cnt", step_cnt, '0);
    tick();
    chk("hold_no_step", step_cnt, '0);

    // single step, then repeated requests during a scan
    do_step("step1", 1'b0);
    randomize_regs();
    do_step("step_hold_req", 1'b1);

    // two armed channels on the same trigger count
    irq_arm = 2'b11;
    irq_at  = {CNT_W'(3), CNT_W'(3)};
    randomize_regs();
    do_step("irq_step3", 1'b0);
    do_step("irq_step4", 1'b0);

    // free-run: channel 0 at 10, channel 1 disarmed at 8, step_req ignored
    irq_arm = 2'b01;
    irq_at  = {CNT_W'(8), CNT_W'(10)};
    run = 1'b1;
    step_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_cnt = exp_cnt + CNT_W'(1);
      chk($sformatf("run_cnt_%0d", i), step_cnt, exp_cnt);
      chk($sformatf("run_irq_%0d", i), interrupter, {1'b0, exp_cnt == CNT_W'(10)});
      chk($sformatf("run_no_step_%0d", i), debug_step, 1'b0);
      chk($sformatf("run_debug_en_%0d", i), debug_en, 1'b0);
    end
    run = 1'b0;
    step_req = 1'b0;
    tick();
    chk("run_stop_cnt", step_cnt, exp_cnt);
    chk("run_stop_debug_en", debug_en, 1'b1);
    tick();
    chk("run_stop_cnt_hold", step_cnt, exp_cnt);
    chk("run_stop_state", st, IDLE);
    irq_arm = '0;

    // reset during a scan while address 15 is on the bus
    for (int k = 0; k < SCAN_DEPTH; k++) core_regs[k] = core_regs[k] ^ ($urandom | 32'd1);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    n = 0;
    while (!(scan_busy && !debug_step && debug_addr == ADDR_W'(15)) && n < 100) begin tick(); n++; end
    chk("abort_at_addr15", debug_addr, ADDR_W'(15));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", st, HOLD);
    chk("abort_scan_done", scan_done, 1'b0);
    chk("abort_cpu_rst", cpu_rst, 1'b1);
    chk("abort_step_cnt", step_cnt, '0);
    chk("abort_debug_addr", debug_addr, '0);
    saw_done = 1'b0;
    n = 0;
    while (cpu_rst === 1'b1 && n < 50) begin
      tick();
      n++;
      if (scan_done) saw_done = 1'b1;
    end
    chk("abort_hold_cycles", n, RST_CYCLES);
    chk("abort_no_done", saw_done, 1'b0);
    exp_cnt = '0;
    for (int k = 0; k < 14; k++) snap_m[k] = core_regs[k];
    check_snapshot("abort_snap");

    // previous-bank comparison: partial abort, unchanged data, then two changed words
    do_step("cmp_after_abort", 1'b0);
    do_step("cmp_same", 1'b0);
    core_regs[20] = ~core_regs[20];
    core_regs[9]  = core_regs[9] + 32'd1;
    do_step("cmp_changed", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_dbg_ctrl.md
Name: mips_dbg_ctrl

Overview:
- Synthesizable debug/stimulus controller for the `mips` core. It drives the core's reset, `debug_en`, `debug_step`, `debug_addr` and `interrupter` ports.
- Generalises the fixed reset pulse and single interrupt line to:
  - a parametrised reset hold;
  - single-step or free-run execution;
  - an automatic post-step register-window snapshot;
  - IRQ_CH programmable interrupt injectors.
- Sits between the host/bench and the core. The snapshot buffer is host-readable.

Parameters:
- ADDR_W, 7, width of debug_addr / snapshot address
- DATA_W, 32, width of debug_data
- RST_CYCLES, 5, cycles cpu_rst is held after rst deasserts (≥1)
- SCAN_DEPTH, 32, debug addresses captured per snapshot (1..2^ADDR_W)
- IRQ_CH, 2, number of interrupt injector channels
- CNT_W, 32, width of step/cycle counter

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- run  in  1  1=free-run mode, 0=single-step mode (sampled in IDLE only)
- step_req  in  1  one-cycle pulse requesting one core step
- cpu_rst  out  1  reset to core
- debug_en  out  1  to core debug_en
- debug_step  out  1  to core debug_step
- debug_addr  out  ADDR_W  to core debug_addr
- debug_data  in  DATA_W  from core, valid 1 cycle after debug_addr
- snap_raddr  in  ADDR_W  snapshot read address
- snap_rdata  out  DATA_W  snapshot read data, combinational from snap_raddr
- scan_busy  out  1  high in STEP/SCAN
- scan_done  out  1  one-cycle pulse when a snapshot completes
- step_cnt  out  CNT_W  completed steps (step mode) or run cycles (run mode)
- irq_arm  in  IRQ_CH  per-channel enable
- irq_at  in  IRQ_CH*CNT_W  per-channel trigger count, channel i at bits [i*CNT_W +: CNT_W]
- interrupter  out  IRQ_CH  to core; one-cycle pulse per channel

Behaviour:
- Reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- Values while rst=1:
  - cpu_rst=1, debug_en=1, debug_step=0, debug_addr=0;
  - scan_busy=0, scan_done=0, step_cnt=0, interrupter=0;
  - state=HOLD, hold counter=RST_CYCLES.
- Snapshot RAM is not cleared by rst.
- HOLD:
  - cpu_rst stays 1 for exactly RST_CYCLES cycles after the first cycle with rst=0.
  - Then cpu_rst=0 and the controller enters IDLE.
  - step_req is ignored in HOLD.
- IDLE:
  - debug_en = ~run.
  - If run=1: step_cnt increments every cycle; step_req is ignored.
  - If run=0 and step_req=1: the next cycle enters STEP.
- STEP (1 cycle):
  - debug_step=1 and step_cnt increments.
  - Then the controller enters SCAN with debug_addr=0.
- SCAN:
  - debug_addr increments by one per cycle, 0..SCAN_DEPTH-1.
  - debug_data is written to snapshot[addr] one cycle after that addr is driven.
  - Total SCAN length is SCAN_DEPTH+1 cycles.
  - On the final write cycle+1: scan_done=1 for one cycle, debug_addr returns to 0, state=IDLE.
- step_req arriving outside IDLE (or with run=1) is dropped, not queued.
- Interrupt injection:
  - interrupter[i] pulses for one cycle on the cycle step_cnt updates to a value equal to irq_at[i] while irq_arm[i]=1.
  - Multiple channels may fire in the same cycle.
  - Counter wrap at 2^CNT_W is modular; a match after wrap fires again.
- Switching run 1→0 in IDLE takes effect next cycle; step_cnt is retained.
- rst during SCAN:
  - the scan is aborted; no scan_done pulse;
  - partially written snapshot entries keep their new values.
- snap_raddr may be read at any time. A read of the address being written in the same cycle returns the old data.

Optional Feature:
- MIPS_DBG_SCAN_CMP_EN defined:
  - adds a second (previous) snapshot bank;
  - each SCAN write compares the new word to the previous bank's word at the same address;
  - adds outputs snap_diff (1) and diff_addr (ADDR_W), both valid on the scan_done cycle and held until the next STEP;
  - diff_addr holds the lowest differing address, or 0 if there is no difference;
  - the previous bank updates with the new word on each write;
  - rst clears both outputs to 0.
- Undefined: a single bank and no extra ports.

Decomposition:
- Package mips_dbg_pkg:
  - state enum {HOLD, IDLE, STEP, SCAN};
  - default parameter constants;
  - localparam for the scan length (SCAN_DEPTH+1).
- One sub-module, mips_dbg_snap_ram: SCAN_DEPTH×DATA_W, one synchronous write port, one asynchronous read port. It is instantiated twice when MIPS_DBG_SCAN_CMP_EN is defined.

Test Plan:
- Reset with RST_CYCLES=5 → cpu_rst high exactly 5 cycles after rst falls; debug_en=1; step_cnt=0.
- run=0, one step_req → debug_step pulses 1 cycle; debug_addr sweeps 0..31; scan_done 34 cycles after step_req; step_cnt=1; snapshot[k] equals the value the bench model drove for addr k.
- step_req repeated every cycle during SCAN → only one step is taken; step_cnt=1 after scan_done.
- irq_arm=2'b11, irq_at={3,3} → both interrupter bits pulse together on step 3 only; run=1 with irq_at[0]=10 → pulse on the cycle step_cnt becomes 10.
- rst asserted mid-SCAN at addr 15 → no scan_done; state HOLD; entries 0..13 new, 14..31 old.
- With MIPS_DBG_SCAN_CMP_EN, the bench model changes word at addr 9 between steps → snap_diff=1, diff_addr=9 on scan_done; no change → snap_diff=0.
